// File: rtl/sw_score_engine.sv
// Smith-Waterman affine-gap scorer: LENGTH-PE systolic array with a load/stream/drain/result controller.
// Define SW_END_POS_EN to add res_tpos, the target end position of the best-scoring cell.
module sw_score_engine #(
    parameter int unsigned SCORE_WIDTH = 12,
    parameter int unsigned LENGTH      = 64,
    parameter int unsigned LOG_LENGTH  = $clog2(LENGTH + 1),
    parameter int unsigned TGT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   q_load,
    output logic                   q_ready,
    input  logic [2*LENGTH-1:0]    query,
    input  logic [LOG_LENGTH-1:0]  query_len,
    input  logic [SCORE_WIDTH-1:0] match,
    input  logic [SCORE_WIDTH-1:0] mismatch,
    input  logic [SCORE_WIDTH-1:0] gap_open,
    input  logic [SCORE_WIDTH-1:0] gap_extend,
    input  logic                   t_valid,
    output logic                   t_ready,
    input  logic [1:0]             t_data,
    input  logic                   t_last,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SCORE_WIDTH-1:0] res_score,
    output logic [TGT_WIDTH-1:0]   res_tlen
`ifdef SW_END_POS_EN
    ,
    output logic [TGT_WIDTH-1:0]   res_tpos
`endif
);

    localparam logic [SCORE_WIDTH-1:0] ZERO     = SCORE_WIDTH'(1) << (SCORE_WIDTH - 1);
    localparam logic [LOG_LENGTH-1:0]  QLEN_MAX = LOG_LENGTH'(LENGTH);

    // Biased subtraction that never drops below the zero score.
    function automatic logic [SCORE_WIDTH-1:0] sub_clamp(input logic [SCORE_WIDTH-1:0] a,
                                                         input logic [SCORE_WIDTH-1:0] b);
        logic [SCORE_WIDTH:0] floor_v;
        floor_v = {1'b0, ZERO} + {1'b0, b};
        return ({1'b0, a} >= floor_v) ? a - b : ZERO;
    endfunction

    function automatic logic [SCORE_WIDTH-1:0] add_sat(input logic [SCORE_WIDTH-1:0] a,
                                                       input logic [SCORE_WIDTH-1:0] b);
        logic [SCORE_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_WIDTH] ? '1 : sum[SCORE_WIDTH-1:0];
    endfunction

    function automatic logic [SCORE_WIDTH-1:0] max2(input logic [SCORE_WIDTH-1:0] a,
                                                    input logic [SCORE_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

    typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

    state_e                 state_q, state_d;
    logic [2*LENGTH-1:0]    query_q, query_d;
    logic [LOG_LENGTH-1:0]  qlen_q, qlen_d, drain_q, drain_d;
    logic [SCORE_WIDTH-1:0] match_q, match_d, mism_q, mism_d;
    logic [SCORE_WIDTH-1:0] gopen_q, gopen_d, gext_q, gext_d;
    logic [TGT_WIDTH-1:0]   tcnt_q, tcnt_d, tlen_q, tlen_d, tcnt_inc;
    logic [SCORE_WIDTH-1:0] score_q, score_d, best_h;
    logic                   load, beat;

    logic                   vld_q [LENGTH];
    logic                   vld_d [LENGTH];
    logic [1:0]             base_q [LENGTH];
    logic [1:0]             base_d [LENGTH];
    logic [SCORE_WIDTH-1:0] h_q [LENGTH];
    logic [SCORE_WIDTH-1:0] h_d [LENGTH];
    logic [SCORE_WIDTH-1:0] e_q [LENGTH];
    logic [SCORE_WIDTH-1:0] e_d [LENGTH];
    logic [SCORE_WIDTH-1:0] f_q [LENGTH];
    logic [SCORE_WIDTH-1:0] f_d [LENGTH];
    logic [SCORE_WIDTH-1:0] dg_q [LENGTH];
    logic [SCORE_WIDTH-1:0] dg_d [LENGTH];
    logic [SCORE_WIDTH-1:0] mx_q [LENGTH];
    logic [SCORE_WIDTH-1:0] mx_d [LENGTH];
    logic                   src_v [LENGTH];
    logic [1:0]             src_b [LENGTH];
    logic [SCORE_WIDTH-1:0] src_h [LENGTH];
    logic [SCORE_WIDTH-1:0] src_f [LENGTH];
`ifdef SW_END_POS_EN
    logic [TGT_WIDTH-1:0]   jt_q [LENGTH];
    logic [TGT_WIDTH-1:0]   jt_d [LENGTH];
    logic [TGT_WIDTH-1:0]   pos_q [LENGTH];
    logic [TGT_WIDTH-1:0]   pos_d [LENGTH];
    logic [TGT_WIDTH-1:0]   src_j [LENGTH];
    logic [TGT_WIDTH-1:0]   tpos_q, tpos_d, best_j;
`endif

    assign load     = (state_q == StIdle) && q_load;
    assign beat     = (state_q == StStream) && t_valid;
    assign tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + TGT_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        query_d = query_q;
        qlen_d  = qlen_q;
        drain_d = drain_q;
        match_d = match_q;
        mism_d  = mism_q;
        gopen_d = gopen_q;
        gext_d  = gext_q;
        tcnt_d  = tcnt_q;
        tlen_d  = tlen_q;
        score_d = score_q;
`ifdef SW_END_POS_EN
        tpos_d  = tpos_q;
`endif
        case (state_q)
            StIdle: begin
                if (q_load) begin
                    state_d = StStream;
                    query_d = query;
                    qlen_d  = (query_len == '0 || query_len > QLEN_MAX) ? QLEN_MAX : query_len;
                    match_d = match;
                    mism_d  = mismatch;
                    gopen_d = gap_open;
                    gext_d  = gap_extend;
                    tcnt_d  = '0;
                end
            end
            StStream: begin
                if (t_valid) begin
                    tcnt_d = tcnt_inc;
                    if (t_last) begin
                        state_d = StDrain;
                        drain_d = LOG_LENGTH'(1);
                    end
                end
            end
            StDrain: begin
                // PE qlen-1 has absorbed the last base once the count reaches qlen.
                if (drain_q == qlen_q) begin
                    state_d = StDone;
                    score_d = best_h - ZERO;
                    tlen_d  = tcnt_q;
`ifdef SW_END_POS_EN
                    tpos_d  = best_j;
`endif
                end else begin
                    drain_d = drain_q + LOG_LENGTH'(1);
                end
            end
            StDone: begin
                if (res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            query_q <= '0;
            qlen_q  <= '0;
            drain_q <= '0;
            match_q <= '0;
            mism_q  <= '0;
            gopen_q <= '0;
            gext_q  <= '0;
            tcnt_q  <= '0;
            tlen_q  <= '0;
            score_q <= '0;
`ifdef SW_END_POS_EN
            tpos_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            query_q <= query_d;
            qlen_q  <= qlen_d;
            drain_q <= drain_d;
            match_q <= match_d;
            mism_q  <= mism_d;
            gopen_q <= gopen_d;
            gext_q  <= gext_d;
            tcnt_q  <= tcnt_d;
            tlen_q  <= tlen_d;
            score_q <= score_d;
`ifdef SW_END_POS_EN
            tpos_q  <= tpos_d;
`endif
        end
    end

    // Left-neighbour view of each PE; PE0 sees the input stream and the zero boundary row.
    always_comb begin
        src_v[0] = beat;
        src_b[0] = t_data;
        src_h[0] = ZERO;
        src_f[0] = ZERO;
`ifdef SW_END_POS_EN
        src_j[0] = tcnt_inc;
`endif
        for (int i = 1; i < LENGTH; i++) begin
            src_v[i] = vld_q[i-1];
            src_b[i] = base_q[i-1];
            src_h[i] = h_q[i-1];
            src_f[i] = f_q[i-1];
`ifdef SW_END_POS_EN
            src_j[i] = jt_q[i-1];
`endif
        end
    end

    always_comb begin
        logic [SCORE_WIDTH-1:0] diag_s, e_n, f_n, h_n;
        diag_s = ZERO;
        e_n    = ZERO;
        f_n    = ZERO;
        h_n    = ZERO;
        for (int i = 0; i < LENGTH; i++) begin
            diag_s = (query_q[2*i +: 2] == src_b[i]) ? add_sat(dg_q[i], match_q)
                                                     : sub_clamp(dg_q[i], mism_q);
            e_n = max2(sub_clamp(h_q[i], gopen_q), sub_clamp(e_q[i], gext_q));
            f_n = max2(sub_clamp(src_h[i], gopen_q), sub_clamp(src_f[i], gext_q));
            h_n = max2(max2(ZERO, diag_s), max2(e_n, f_n));

            vld_d[i]  = src_v[i];
            base_d[i] = base_q[i];
            h_d[i]    = h_q[i];
            e_d[i]    = e_q[i];
            f_d[i]    = f_q[i];
            dg_d[i]   = dg_q[i];
            mx_d[i]   = mx_q[i];
`ifdef SW_END_POS_EN
            jt_d[i]   = jt_q[i];
            pos_d[i]  = pos_q[i];
`endif
            if (load) begin
                vld_d[i] = 1'b0;
                h_d[i]   = ZERO;
                e_d[i]   = ZERO;
                f_d[i]   = ZERO;
                dg_d[i]  = ZERO;
                mx_d[i]  = ZERO;
`ifdef SW_END_POS_EN
                jt_d[i]  = '0;
                pos_d[i] = '0;
`endif
            end else if (src_v[i]) begin
                base_d[i] = src_b[i];
                h_d[i]    = h_n;
                e_d[i]    = e_n;
                f_d[i]    = f_n;
                dg_d[i]   = src_h[i];
`ifdef SW_END_POS_EN
                jt_d[i]   = src_j[i];
`endif
                if (h_n > mx_q[i]) begin
                    mx_d[i]  = h_n;
`ifdef SW_END_POS_EN
                    pos_d[i] = src_j[i];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LENGTH; i++) begin
            if (!rst) begin
                vld_q[i]  <= 1'b0;
                base_q[i] <= 2'b00;
                h_q[i]    <= ZERO;
                e_q[i]    <= ZERO;
                f_q[i]    <= ZERO;
                dg_q[i]   <= ZERO;
                mx_q[i]   <= ZERO;
`ifdef SW_END_POS_EN
                jt_q[i]   <= '0;
                pos_q[i]  <= '0;
`endif
            end else begin
                vld_q[i]  <= vld_d[i];
                base_q[i] <= base_d[i];
                h_q[i]    <= h_d[i];
                e_q[i]    <= e_d[i];
                f_q[i]    <= f_d[i];
                dg_q[i]   <= dg_d[i];
                mx_q[i]   <= mx_d[i];
`ifdef SW_END_POS_EN
                jt_q[i]   <= jt_d[i];
                pos_q[i]  <= pos_d[i];
`endif
            end
        end
    end

    // Ascending scan with strict compare keeps the smallest PE index on equal score and position.
    always_comb begin
        best_h = ZERO;
`ifdef SW_END_POS_EN
        best_j = '0;
`endif
        for (int i = 0; i < LENGTH; i++) begin
            if (i < int'(qlen_q)) begin
`ifdef SW_END_POS_EN
                if (mx_q[i] > best_h || (mx_q[i] == best_h && pos_q[i] < best_j)) begin
                    best_h = mx_q[i];
                    best_j = pos_q[i];
                end
`else
                if (mx_q[i] > best_h) best_h = mx_q[i];
`endif
            end
        end
    end

    assign q_ready   = (state_q == StIdle);
    assign t_ready   = (state_q == StStream);
    assign res_valid = (state_q == StDone);
    assign res_score = score_q;
    assign res_tlen  = tlen_q;
`ifdef SW_END_POS_EN
    assign res_tpos  = tpos_q;
`endif

endmodule

// File: tb/tb_sw_score_engine.sv
// Bench for sw_score_engine: directed jobs plus randomized jobs against a dynamic-programming model.
module tb_sw_score_engine;
    localparam int SW  = 12;
    localparam int LEN = 64;
    localparam int LL  = 7;
    localparam int TW  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            q_load = 1'b0;
    logic            q_ready;
    logic [2*LEN-1:0] query = '0;
    logic [LL-1:0]   query_len = '0;
    logic [SW-1:0]   match = '0, mismatch = '0, gap_open = '0, gap_extend = '0;
    logic            t_valid = 1'b0;
    logic            t_ready;
    logic [1:0]      t_data = 2'b00;
    logic            t_last = 1'b0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [SW-1:0]   res_score;
    logic [TW-1:0]   res_tlen;
`ifdef SW_END_POS_EN
    logic [TW-1:0]   res_tpos;
`endif

    sw_score_engine dut (
        .clk        (clk),
        .rst        (rst),
        .q_load     (q_load),
        .q_ready    (q_ready),
        .query      (query),
        .query_len  (query_len),
        .match      (match),
        .mismatch   (mismatch),
        .gap_open   (gap_open),
        .gap_extend (gap_extend),
        .t_valid    (t_valid),
        .t_ready    (t_ready),
        .t_data     (t_data),
        .t_last     (t_last),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_score  (res_score),
        .res_tlen   (res_tlen)
`ifdef SW_END_POS_EN
        ,
        .res_tpos   (res_tpos)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [2*LEN-1:0] cur_query;
    int               cur_ql, cur_m, cur_mm, cur_go, cur_ge;
    logic [1:0]       tgt_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] base_of(input byte c);
        case (c)
            "A":     return 2'b10;
            "G":     return 2'b11;
            "T":     return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    // Named bases first, random junk in every position beyond them.
    function automatic logic [2*LEN-1:0] mk_query(input string s);
        logic [2*LEN-1:0] q;
        q = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < s.len(); i++) q[2*i +: 2] = base_of(s[i]);
        return q;
    endfunction

    task automatic set_target(input string s);
        tgt_q.delete();
        for (int i = 0; i < s.len(); i++) tgt_q.push_back(base_of(s[i]));
    endtask

    function automatic int eff_qlen(input int ql);
        return (ql == 0 || ql > LEN) ? LEN : ql;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Column-by-column Smith-Waterman with affine gaps over plain signed integers.
    function automatic void ref_model(output int score, output int pos);
        int hcol[LEN+1];
        int ecol[LEN+1];
        int ql, hdiag, hup, fup, s, e, f, h;
        ql = eff_qlen(cur_ql);
        score = 0;
        pos = 0;
        for (int i = 0; i <= LEN; i++) begin
            hcol[i] = 0;
            ecol[i] = 0;
        end
        for (int j = 1; j <= tgt_q.size(); j++) begin
            hdiag = 0;
            hup = 0;
            fup = 0;
            for (int i = 1; i <= ql; i++) begin
                s = (cur_query[2*(i-1) +: 2] == tgt_q[j-1]) ? cur_m : -cur_mm;
                e = imax(hcol[i] - cur_go, ecol[i] - cur_ge);
                f = imax(hup - cur_go, fup - cur_ge);
                h = imax(imax(0, hdiag + s), imax(e, f));
                hdiag = hcol[i];
                hcol[i] = h;
                ecol[i] = e;
                hup = h;
                fup = f;
                if (h > score) begin
                    score = h;
                    pos = j;
                end
            end
        end
    endfunction

    task automatic check_idle_after_reset(input string tag);
        check_eq({tag, "_q_ready"}, 32'(q_ready), 1);
        check_eq({tag, "_t_ready"}, 32'(t_ready), 0);
        check_eq({tag, "_res_valid"}, 32'(res_valid), 0);
        check_eq({tag, "_res_score"}, 32'(res_score), 0);
        check_eq({tag, "_res_tlen"}, 32'(res_tlen), 0);
    endtask

    task automatic load_job(input logic [2*LEN-1:0] q, input int ql, input int m, input int mm,
                            input int go, input int ge);
        int w;
        w = 0;
        cur_query = q;
        cur_ql = ql;
        cur_m = m;
        cur_mm = mm;
        cur_go = go;
        cur_ge = ge;
        while (!q_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!q_ready) check_eq("q_ready_wait", 32'(q_ready), 1);
        query = q;
        query_len = LL'(ql);
        match = SW'(m);
        mismatch = SW'(mm);
        gap_open = SW'(go);
        gap_extend = SW'(ge);
        q_load = 1'b1;
        @(negedge clk);
        q_load = 1'b0;
        check_eq("t_ready_after_load", 32'(t_ready), 1);
    endtask

    // mode 0: back-to-back beats, 1: every other cycle, 2: random gaps. spec_score < 0 skips.
    task automatic run_job(input string tag, input int mode, input int hold, input int spec_score);
        int idx, guard, last_cyc, w, exp_s, exp_p, n;
        logic v, acc;
        idx = 0;
        guard = 0;
        last_cyc = 0;
        w = 0;
        n = tgt_q.size();
        ref_model(exp_s, exp_p);
        if (spec_score >= 0) check_eq({tag, "_model_vs_spec"}, 32'(exp_s), 32'(spec_score));
        while (idx < n && guard < 2000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 0;
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            t_valid = v;
            t_data = tgt_q[idx];
            t_last = (idx == n - 1);
            acc = v && t_ready;
            if (acc) last_cyc = cyc;
            @(negedge clk);
            if (acc) idx++;
            guard++;
        end
        t_valid = 1'b0;
        t_last = 1'b0;
        check_eq({tag, "_beats"}, 32'(idx), 32'(n));
        check_eq({tag, "_t_ready_drop"}, 32'(t_ready), 0);
        while (!res_valid && w < 300) begin
            @(negedge clk);
            w++;
        end
        check_eq({tag, "_res_valid"}, 32'(res_valid), 1);
        check_eq({tag, "_latency"}, 32'(cyc - last_cyc), 32'(eff_qlen(cur_ql) + 1));
        check_eq({tag, "_score"}, 32'(res_score), 32'(exp_s));
        check_eq({tag, "_tlen"}, 32'(res_tlen), 32'(n));
`ifdef SW_END_POS_EN
        check_eq({tag, "_tpos"}, 32'(res_tpos), 32'(exp_p));
`endif
        check_eq({tag, "_q_ready_done"}, 32'(q_ready), 0);
        for (int k = 0; k < hold; k++) begin
            q_load = 1'b1;
            query = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, 32'(res_valid), 1);
            check_eq({tag, "_hold_score"}, 32'(res_score), 32'(exp_s));
            check_eq({tag, "_hold_q_ready"}, 32'(q_ready), 0);
            check_eq({tag, "_hold_t_ready"}, 32'(t_ready), 0);
        end
        q_load = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_eq({tag, "_idle_q_ready"}, 32'(q_ready), 1);
        check_eq({tag, "_idle_res_valid"}, 32'(res_valid), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ql, n;
        repeat (2) @(negedge clk);
        check_idle_after_reset("reset");
        rst = 1'b1;
        @(negedge clk);

        // match=2 mismatch=1 gap_open=3 gap_extend=1 for the directed jobs
        load_job(mk_query("ACGT"), 4, 2, 1, 3, 1);
        set_target("ACGT");
        run_job("t1", 0, 0, 8);

        load_job(mk_query("AAAA"), 4, 2, 1, 3, 1);
        set_target("TTTT");
        run_job("t2", 0, 0, 0);

        load_job(mk_query("ACGT"), 4, 2, 1, 3, 1);
        set_target("ACGGT");
        run_job("t3", 1, 0, 6);

        load_job(mk_query("AC"), 2, 2, 1, 3, 1);
        set_target("AC");
        run_job("t4", 0, 0, 4);

        load_job(mk_query("ACGT"), 4, 2, 1, 3, 1);
        set_target("ACGT");
        run_job("t5", 2, 10, 8);

        // Abandon a job mid-stream with reset.
        load_job(mk_query("ACGT"), 4, 2, 1, 3, 1);
        set_target("ACGTACGT");
        for (int i = 0; i < 3; i++) begin
            t_valid = 1'b1;
            t_data = tgt_q[i];
            t_last = 1'b0;
            @(negedge clk);
        end
        t_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_idle_after_reset("midrst");
        rst = 1'b1;
        @(negedge clk);
        load_job(mk_query("G"), 1, 2, 1, 3, 1);
        set_target("G");
        run_job("t6", 0, 0, 2);

        for (int r = 0; r < 25; r++) begin
            case ($urandom_range(0, 5))
                0:       ql = $urandom_range(0, 1) ? 0 : $urandom_range(65, 127);
                1:       ql = $urandom_range(1, 4);
                default: ql = $urandom_range(1, 64);
            endcase
            load_job({$urandom, $urandom, $urandom, $urandom}, ql, $urandom_range(1, 5),
                     $urandom_range(0, 4), $urandom_range(0, 6), $urandom_range(0, 3));
            tgt_q.delete();
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) tgt_q.push_back(2'($urandom_range(0, 3)));
            run_job($sformatf("rnd%0d", r), $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
